// File: rtl/fixed_power_pkg.sv
// Shared widths, Q10.10 constants and the state encoding for the fixed_power block.
package fixed_power_pkg;

  localparam int unsigned Q_WIDTH    = 20;
  localparam int unsigned FRAC_BITS  = 10;
  localparam int unsigned N_WIDTH    = 3;
  localparam int unsigned PROD_WIDTH = 2 * Q_WIDTH;

  localparam logic [Q_WIDTH-1:0] Q_ONE = 20'h00400;
  localparam logic [Q_WIDTH-1:0] Q_SAT = 20'hFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/fixed_power_q10_mul.sv
// Combinational Q10.10 multiply: truncated Q10.10 product plus an integer-overflow flag.
module q10_mul
  import fixed_power_pkg::*;
(
  input  logic [Q_WIDTH-1:0] a,
  input  logic [Q_WIDTH-1:0] b,
  output logic [Q_WIDTH-1:0] p,
  output logic               ovf
);

  localparam int unsigned SHIFT_WIDTH = PROD_WIDTH - FRAC_BITS;

  logic [PROD_WIDTH-1:0]  prod;
  logic [SHIFT_WIDTH-1:0] prod_shr;

  assign prod     = PROD_WIDTH'(a) * PROD_WIDTH'(b);
  // Dropping the fraction LSBs is the truncation; anything above Q_WIDTH is overflow.
  assign prod_shr = SHIFT_WIDTH'(prod >> FRAC_BITS);
  assign p        = prod_shr[Q_WIDTH-1:0];
  assign ovf      = |prod_shr[SHIFT_WIDTH-1:Q_WIDTH];

endmodule

// File: rtl/fixed_power.sv
// Iterative Q10.10 integer power: one multiply per cycle, saturating with early exit on overflow.
module fixed_power
  import fixed_power_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [Q_WIDTH-1:0] in_data_1,
  input  logic [N_WIDTH-1:0] in_data_2,
  output logic               in_ready,
  output logic               out_valid,
  output logic [Q_WIDTH-1:0] out_data,
  output logic               out_ovf
);

  state_e               state_q, state_d;
  logic [Q_WIDTH-1:0]   base_q, base_d;
  logic [Q_WIDTH-1:0]   acc_q, acc_d;
  logic [N_WIDTH-1:0]   n_q, n_d;
  logic [N_WIDTH-1:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [Q_WIDTH-1:0]   out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;

  logic [Q_WIDTH-1:0]   mul_p;
  logic                 mul_ovf;

  q10_mul u_mul (
    .a   (acc_q),
    .b   (base_q),
    .p   (mul_p),
    .ovf (mul_ovf)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    acc_d       = acc_q;
    n_d         = n_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_ovf_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          base_d  = in_data_1;
          n_d     = in_data_2;
          acc_d   = in_data_1;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = (in_data_2 < N_WIDTH'(2)) ? OUT : MUL;
        end
      end
      MUL: begin
        count_d = N_WIDTH'(count_q + N_WIDTH'(1));
        if (mul_ovf) begin
          acc_d   = Q_SAT;
          ovf_d   = 1'b1;
          state_d = OUT;
        end else begin
          acc_d = mul_p;
          if (count_d == N_WIDTH'(n_q - N_WIDTH'(1))) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        out_valid_d = 1'b1;
        out_ovf_d   = ovf_q;
        if (n_q == N_WIDTH'(0)) begin
          out_data_d = Q_ONE;
        end else if (n_q == N_WIDTH'(1)) begin
          out_data_d = base_q;
        end else begin
          out_data_d = acc_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      acc_q       <= '0;
      n_q         <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fixed_power.sv
// Directed vector table, hand-written corner sequences and random requests checked against an arithmetic model.
module tb_fixed_power;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] in_data_1;
  logic [2:0]  in_data_2;
  logic        in_ready;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  fixed_power dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] base;
    logic [2:0]  n;
    logic [19:0] exp_data;
    logic        exp_ovf;
    int          exp_lat;
    bit          pulse_mid;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Power by repeated multiplication with the result scaled back to Q10.10 each step.
  function automatic void model(input logic [19:0] b, input logic [2:0] n,
                                output logic [19:0] d, output logic o, output int lat);
    longint unsigned acc, prod;
    o   = 1'b0;
    lat = (n < 2) ? 1 : int'(n);
    if (n == 0) begin
      d = 20'h00400;
      return;
    end
    acc = longint'(b);
    for (int m = 1; m < int'(n); m++) begin
      prod = acc * longint'(b);
      if (prod >= (64'd1 << 30)) begin
        d   = 20'hFFFFF;
        o   = 1'b1;
        lat = m + 1;
        return;
      end
      acc = prod >> 10;
    end
    d = 20'(acc);
  endfunction

  task automatic do_req(input logic [19:0] b, input logic [2:0] n, input logic [19:0] exp_d,
                        input logic exp_o, input int exp_lat, input bit pulse, input string tag);
    int          lat = 0;
    int          pulses = 0;
    bit          junk = 0;
    logic [19:0] got_d = '0;
    logic        got_o = 1'b0;
    @(negedge clk);
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data_1 = b;
    in_data_2 = n;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data_1 = 20'($urandom);
    in_data_2 = 3'($urandom);
    for (int c = 1; c <= 12; c++) begin
      if (pulse && c == 1) in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (lat == 0) begin
          lat   = c;
          got_d = out_data;
          got_o = out_ovf;
        end
      end else if (out_data != 20'h0 || out_ovf) begin
        junk = 1'b1;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".data"}, 32'(got_d), 32'(exp_d));
    check({tag, ".ovf"}, 32'(got_o), 32'(exp_o));
    check({tag, ".pulses"}, 32'(pulses), 32'd1);
    check({tag, ".idle_zero"}, 32'(junk), 32'd0);
  endtask

  // Hold in_valid high and count result strobes over a fixed window.
  task automatic stream(input logic [2:0] n, input int cycles, input int exp_pulses, input string tag);
    int pulses = 0;
    int first  = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = 20'h00800;
    in_data_2 = n;
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    in_valid = 1'b0;
    check({tag, ".pulses"}, 32'(pulses), 32'(exp_pulses));
    check({tag, ".first"}, 32'(first), 32'((n < 2) ? 2 : int'(n) + 1));
    repeat (10) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] b, d;
    logic [2:0]  n;
    logic        o;
    int          lat;
    int          pulses;

    vecs[0]  = '{20'h00800, 3'd3, 20'h02000, 1'b0, 3, 1'b0};
    vecs[1]  = '{20'h00600, 3'd2, 20'h00900, 1'b0, 2, 1'b0};
    vecs[2]  = '{20'h12345, 3'd0, 20'h00400, 1'b0, 1, 1'b0};
    vecs[3]  = '{20'h12345, 3'd1, 20'h12345, 1'b0, 1, 1'b0};
    vecs[4]  = '{20'h04000, 3'd7, 20'hFFFFF, 1'b1, 3, 1'b0};
    vecs[5]  = '{20'h00001, 3'd2, 20'h00000, 1'b0, 2, 1'b1};
    vecs[6]  = '{20'h00000, 3'd0, 20'h00400, 1'b0, 1, 1'b0};
    vecs[7]  = '{20'h00000, 3'd5, 20'h00000, 1'b0, 5, 1'b0};
    vecs[8]  = '{20'hFFFFF, 3'd1, 20'hFFFFF, 1'b0, 1, 1'b0};
    vecs[9]  = '{20'hFFFFF, 3'd2, 20'hFFFFF, 1'b1, 2, 1'b0};
    vecs[10] = '{20'h00400, 3'd7, 20'h00400, 1'b0, 7, 1'b0};
    vecs[11] = '{20'h00C00, 3'd4, 20'h14400, 1'b0, 4, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    check("reset.out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_req(vecs[i].base, vecs[i].n, vecs[i].exp_data, vecs[i].exp_ovf,
             vecs[i].exp_lat, vecs[i].pulse_mid, $sformatf("vec%0d", i));

    // Back-to-back spacing with in_valid held high.
    stream(3'd0, 8, 4, "b2b_n0");
    stream(3'd2, 9, 3, "b2b_n2");

    // Reset in the middle of 2.0^7.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = 20'h00800;
    in_data_2 = 3'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_reset.in_ready", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) pulses++;
      @(posedge clk);
      #1;
    end
    check("mid_reset.no_valid", 32'(pulses), 32'd0);
    do_req(20'h00800, 3'd3, 20'h02000, 1'b0, 3, 1'b0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      b = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 20'h01000)) : 20'($urandom);
      n = 3'($urandom);
      model(b, n, d, o, lat);
      do_req(b, n, d, o, lat, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fixed_power.md
FIXED_POWER -- requirements
Module: fixed_power

Interface
REQ-001 The block SHALL use reset rst_n, synchronous, active-low; clock clk.
REQ-002 Port list SHALL be:
  clk        in   1   clock, all state on rising edge
  rst_n      in   1   synchronous active-low reset
  in_valid   in   1   request strobe, sampled only while in_ready=1
  in_data_1  in   20  base, unsigned Q10.10
  in_data_2  in   3   exponent n, unsigned integer 0..7
  in_ready   out  1   high while idle, request accepted
  out_valid  out  1   one-cycle result strobe
  out_data   out  20  result base^n, unsigned Q10.10
  out_ovf    out  1   result saturated, qualified by out_valid

Function
REQ-003 States SHALL be IDLE, MUL, OUT; in_ready SHALL equal (state==IDLE).
REQ-004 In IDLE with in_valid=1 the block SHALL register base and n; n=0 or n=1 SHALL go to OUT, n>=2 SHALL go to MUL with acc=base and count=0.
REQ-005 In IDLE with in_valid=0 the block SHALL remain in IDLE; in_valid in MUL or OUT SHALL be ignored, with no queueing.
REQ-006 Each MUL cycle SHALL compute a 40-bit product acc*base.
  - New acc SHALL be product[29:10], truncated with no rounding.
  - The count SHALL increment by 1.
REQ-007 Overflow SHALL mean product[39:30] != 0.
  - On overflow acc SHALL become 20'hFFFFF and the ovf flag SHALL set.
  - The FSM SHALL go directly to OUT (early termination).
REQ-008 MUL SHALL exit to OUT after exactly n-1 multiplications when no overflow occurs.
REQ-009 OUT SHALL last one cycle, then return to IDLE.
  - out_valid=1 for that single cycle.
  - out_data=acc, or 20'h00400 (1.0) when n=0, or base when n=1.
  - out_ovf=ovf flag.
REQ-010 When out_valid=0, out_data SHALL be 20'h0 and out_ovf SHALL be 0.
REQ-011 Latency: with in_valid sampled at edge k, out_valid SHALL rise at edge k+max(n,1) without overflow, and at edge k+m+1 when overflow occurs on multiplication m.
REQ-012 Boundary: 0^0 SHALL give 20'h00400; 0^n for n>=1 SHALL give 20'h0; base 20'hFFFFF with n=1 SHALL give 20'hFFFFF with out_ovf=0.
REQ-013 Back-to-back: a new request SHALL be accepted at the first IDLE cycle after out_valid, giving a minimum spacing of max(n,1)+1 cycles.
REQ-014 The block SHALL use only one 20x20 multiplier instance, with no combinational path from inputs to outputs.

Reset
REQ-015 With rst_n=0 at a rising edge the block SHALL force:
  - state=IDLE
  - acc, count, registered base, registered n and ovf flag = 0
  - out_valid=0, out_data=0, out_ovf=0
REQ-016 Reset during MUL or OUT SHALL abort the operation without emitting out_valid, and in_ready SHALL be 1 in the first cycle after rst_n returns high.

Structure
REQ-017 Package fixed_power_pkg SHALL hold:
  - Q_WIDTH=20, FRAC_BITS=10
  - Q_ONE=20'h00400, Q_SAT=20'hFFFFF
  - the state enum {IDLE, MUL, OUT}
REQ-018 A combinational sub-module q10_mul SHALL take two Q10.10 operands and return the truncated Q10.10 product and an overflow bit; the FSM, counter and output registers SHALL live in fixed_power.

Verification
REQ-019 Bench SHALL cover: base 20'h00800 (2.0), n=3 -> out_data 20'h02000 (8.0), out_ovf=0, out_valid at edge k+3.
REQ-020 Bench SHALL cover: base 20'h00600 (1.5), n=2 -> out_data 20'h00900 (2.25) at edge k+2.
REQ-021 Bench SHALL cover: base 20'h12345, n=0 -> out_data 20'h00400 at edge k+1; same base, n=1 -> 20'h12345 at edge k+1.
REQ-022 Bench SHALL cover: base 20'h04000 (16.0), n=7 -> out_data 20'hFFFFF, out_ovf=1, out_valid at edge k+3 (early termination).
REQ-023 Bench SHALL cover: base 20'h00001, n=2 -> out_data 20'h0 (truncation); in_valid pulsed during MUL -> ignored, exactly one out_valid.
REQ-024 Bench SHALL cover: rst_n=0 for one cycle during MUL of 2.0^7 -> no out_valid, in_ready=1 next cycle; a following 2.0^3 request -> 20'h02000.
